// File: rtl/conv_pixel_streamer.sv
// -----------------------------------------------------------------------------
// conv_pixel_streamer
//   Source end of the convolver pixel interface. The host loads one
//   IMAGE_SIZE x IMAGE_SIZE frame into an internal buffer; a start pulse then
//   streams it in raster order (row 0 col 0 first), one pixel per clock, as
//   pixel_out/write. hold pauses the stream without skipping or repeating a
//   pixel. busy and done report progress and completion.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   load_en    host write strobe (ignored while busy or for load_addr >= N)
//   load_addr  raster address row*IMAGE_SIZE+col
//   load_data  pixel value to store
//   start      begin streaming the stored frame (sampled in IDLE only)
//   hold       pause the stream while high
//   pixel_out  current pixel (keeps its last value after the stream)
//   write      pixel_out valid this cycle
//   row_idx    row of the pixel on pixel_out
//   col_idx    column of the pixel on pixel_out
//   busy       high while pixels are being streamed
//   done       one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module conv_pixel_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BIT   = 8,
  parameter int IMAGE_SIZE = 28,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  start,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] row_idx,
  output logic [ADDR_WIDTH-1:0] col_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int PIX_N = IMAGE_SIZE * IMAGE_SIZE;
  // One bit wider than the load address so "all N pixels issued" is
  // representable even when N == 2**ADDR_WIDTH.
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]         PIX_COUNT = PW'(PIX_N);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(IMAGE_SIZE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Pixel format is Q(DATA_WIDTH-FRAC_BIT).FRAC_BIT; values pass through
  // untouched, so FRAC_BIT only needs to be a legal split of the word.
  if (((1 << ADDR_WIDTH) < PIX_N) || (FRAC_BIT >= DATA_WIDTH)) begin : g_param_check
    $error("conv_pixel_streamer: illegal parameter combination");
  end

  logic [1:0]            state;
  logic [PW-1:0]         ptr;        // index of the next pixel to issue
  logic [ADDR_WIDTH-1:0] next_row;   // row/col of the next pixel to issue
  logic [ADDR_WIDTH-1:0] next_col;
  logic                  first;      // next issue is pixel 0, which ignores hold
  logic                  load_ok;
  logic                  issue;

  logic [DATA_WIDTH-1:0] frame_mem [0:PIX_N-1];

  assign load_ok = load_en && !busy && ({1'b0, load_addr} < PIX_COUNT);
  assign issue   = (state == S_STREAM) && (ptr != PIX_COUNT) && (first || !hold);

  // NOTE: the frame buffer has no reset on purpose: a reset must not erase a
  // loaded frame, and leaving it out keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      frame_mem[load_addr] <= load_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      next_row  <= '0;
      next_col  <= '0;
      first     <= 1'b0;
      pixel_out <= '0;
      write     <= 1'b0;
      row_idx   <= '0;
      col_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      write <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_STREAM;
            ptr      <= '0;
            next_row <= '0;
            next_col <= '0;
            first    <= 1'b1;
          end
        end

        S_STREAM: begin
          if (ptr == PIX_COUNT) begin
            // Last pixel went out on the previous edge.
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (issue) begin
            pixel_out <= frame_mem[ptr[ADDR_WIDTH-1:0]];
            write     <= 1'b1;
            busy      <= 1'b1;
            row_idx   <= next_row;
            col_idx   <= next_col;
            ptr       <= ptr + 1'b1;
            first     <= 1'b0;
            if (next_col == COL_LAST) begin
              next_col <= '0;
              next_row <= next_row + 1'b1;
            end else begin
              next_col <= next_col + 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pixel_streamer.sv
// -----------------------------------------------------------------------------
// tb_conv_pixel_streamer
//   Self-checking bench for conv_pixel_streamer. A reference frame array in
//   the bench mirrors what the host loaded; the expected stream is derived
//   from it pixel by pixel (pixel p at raster position p/IMAGE_SIZE,
//   p%IMAGE_SIZE), with random or directed hold gaps applied.
// -----------------------------------------------------------------------------
module tb_conv_pixel_streamer;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int IS = 28;
  localparam int N  = IS * IS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [DW-1:0] pixel_out;
  logic          write;
  logic [AW-1:0] row_idx;
  logic [AW-1:0] col_idx;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [N];

  always #5 clk = ~clk;

  conv_pixel_streamer #(
    .DATA_WIDTH(DW),
    .FRAC_BIT  (8),
    .IMAGE_SIZE(IS),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .start    (start),
    .hold     (hold),
    .pixel_out(pixel_out),
    .write    (write),
    .row_idx  (row_idx),
    .col_idx  (col_idx),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pack(input bit w, input bit b, input bit d,
                                       input int r, input int c,
                                       input logic [DW-1:0] px);
    return {25'd0, w, b, d, AW'(r), AW'(c), px};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {25'd0, write, busy, done, row_idx, col_idx, pixel_out};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ramp mem[i]=i, mode 1: constant 16'h0140, otherwise random
  task automatic load_frame(input int mode);
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      d = (mode == 0) ? DW'(i) : (mode == 1) ? 16'h0140 : DW'($urandom);
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = d;
      tick();
      ref_mem[i] = d;
    end
    load_en = 1'b0;
  endtask

  // Stream one frame and check every cycle against the reference.
  //   hold_pct   : random hold probability (0..99); >0 also holds on edge k+1
  //   hold_after : if >=0, hold for 3 cycles right after that pixel is issued
  //   poke_at    : if >=0, drive start + load_en(addr 5) while pixel index is here
  //   abort_at   : if >=0, assert reset when this many pixels have been issued
  //   same_addr  : if >=0, load that address on the same edge as start
  task automatic stream_frame(input int hold_pct, input int hold_after,
                              input int poke_at, input int abort_at,
                              input int same_addr);
    int p = 0;
    int cyc = 0;
    int burst = 0;
    bit h;
    bit directed;
    logic [DW-1:0] sd;
    logic [63:0] exp;

    start = 1'b1;
    if (same_addr >= 0) begin
      sd        = DW'($urandom);
      load_en   = 1'b1;
      load_addr = AW'(same_addr);
      load_data = sd;
    end
    tick();  // edge k: start accepted, nothing issued yet
    start   = 1'b0;
    load_en = 1'b0;
    if (same_addr >= 0) ref_mem[same_addr] = sd;
    check("accept_edge", {61'd0, write, busy, done}, 64'd0);

    while (p < N && cyc < 4 * N) begin
      directed = (hold_after >= 0) && (p == hold_after + 1) && (burst < 3);
      if (directed) burst++;
      h = directed || (hold_pct > 0 && (cyc == 0 || $urandom_range(99) < hold_pct));
      hold = h;
      if (p == poke_at) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = AW'(5);
        load_data = ~ref_mem[5];
      end
      if (p == abort_at) begin
        hold  = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_now", dut_vec(), 64'd0);
        tick();
        check("abort_held", dut_vec(), 64'd0);
        reset = 1'b1;
        tick();
        check("abort_no_done", {61'd0, write, busy, done}, 64'd0);
        tick();
        check("abort_idle", {61'd0, write, busy, done}, 64'd0);
        return;
      end
      tick();
      cyc++;
      start   = 1'b0;
      load_en = 1'b0;
      if (cyc == 1 || !h) begin
        exp = pack(1'b1, 1'b1, 1'b0, p / IS, p % IS, ref_mem[p]);
        p++;
      end else begin
        exp = pack(1'b0, 1'b1, 1'b0, (p - 1) / IS, (p - 1) % IS, ref_mem[p - 1]);
      end
      check("stream", dut_vec(), exp);
    end

    if (p < N) begin
      check("stream_timeout", 64'(p), 64'(N));
      hold = 1'b0;
      return;
    end

    hold = 1'(($urandom_range(1)));  // hold in DONE has no effect
    tick();
    check("done_pulse", {44'd0, write, busy, done, pixel_out},
          {44'd0, 1'b0, 1'b0, 1'b1, ref_mem[N - 1]});
    hold = 1'b0;
    tick();
    check("back_idle", {44'd0, write, busy, done, pixel_out},
          {44'd0, 1'b0, 1'b0, 1'b0, ref_mem[N - 1]});
  endtask

  initial begin
    // Reset values and quiet idle
    #2 reset = 1'b0;
    #1;
    check("reset_outputs", dut_vec(), 64'd0);
    #20 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_quiet", {61'd0, write, busy, done}, 64'd0);
    end

    // Ramp frame, uninterrupted stream
    load_frame(0);
    stream_frame(0, -1, -1, -1, -1);

    // Constant frame, three hold cycles right after pixel 27
    load_frame(1);
    stream_frame(0, 27, -1, -1, -1);

    // Random frame; start and load_en while busy must be ignored, which the
    // following random-hold frame confirms by re-streaming mem[5]
    load_frame(2);
    stream_frame(0, -1, 100, -1, -1);
    stream_frame(25, -1, -1, -1, -1);

    // Reset at pixel 300, then a full restart from pixel 0 with intact frame
    stream_frame(0, -1, -1, 300, -1);
    stream_frame(10, -1, -1, -1, -1);

    // Out-of-range load is dropped
    load_en   = 1'b1;
    load_addr = AW'(N + int'($urandom_range(1023 - N)));
    load_data = ~ref_mem[0];
    tick();
    load_en = 1'b0;

    // Load on the start edge is visible to the stream
    stream_frame(0, -1, -1, -1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
